operand_forward_stage: RTL and testbench
========================================

OPERAND_FORWARD_STAGE -- requirements
Module: operand_forward_stage

Interface
REQ-001 Parameter DATA_W, default 32, shall set the operand and result width.
REQ-002 Parameter RA_W, default 5, shall set the register-address width.
REQ-003 Parameter MDU_LAT, default 4, range 2..15, shall set the multiply/divide occupancy in cycles.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 id_valid, id_alusrc, id_regwrite, id_memtoreg, id_mdu  input  1 each  decode-stage valid and control bits; id_mdu marks a multiply/divide op.
REQ-007 id_rs, id_rt, id_wreg  input  RA_W each  decode-stage source and destination registers.
REQ-008 id_rd1, id_rd2, id_imm  input  DATA_W each  register-file read data and sign-extended immediate.
REQ-009 mem_aluout  input  DATA_W; mem_wreg  input  RA_W; mem_regwrite  input  1: MEM-stage result.
REQ-010 wb_result  input  DATA_W; wb_wreg  input  RA_W; wb_regwrite  input  1: WB-stage result.
REQ-011 stall_id  output  1  holds fetch/decode this cycle.
REQ-012 ex_srca, ex_srcb, ex_wdata  output  DATA_W each  forwarded ALU operands and store data.
REQ-013 ex_valid, ex_regwrite, ex_memtoreg, ex_mdu  output  1 each; ex_wreg  output  RA_W: registered EX-stage control.
REQ-014 fwd_a, fwd_b  output  2 each  selected source: 00 register, 01 WB, 10 MEM.
REQ-015 mdu_busy  output  1  multiply/divide unit occupied.

Function
REQ-016 The EX register shall capture the id_* fields every cycle when stall_id=0.
REQ-017 When stall_id=1, the EX register shall load a bubble: ex_valid=0, ex_regwrite=0, ex_memtoreg=0, ex_mdu=0; other fields are don't-care.
REQ-018 Load-use hazard: stall_id=1 when id_valid, ex_valid, ex_regwrite and ex_memtoreg are all 1, ex_wreg!=0, and ex_wreg equals id_rs or id_rt.
REQ-019 MDU hazard: stall_id=1 when id_valid, id_mdu and mdu_busy are all 1.
REQ-020 Coincident load-use and MDU hazards shall produce one stall cycle per clock, not additive stalls.
REQ-021 fwd_a shall be 10 when mem_regwrite=1, mem_wreg!=0 and mem_wreg equals the registered rs.
REQ-022 Otherwise fwd_a shall be 01 when wb_regwrite=1, wb_wreg!=0 and wb_wreg equals the registered rs.
REQ-023 Otherwise fwd_a shall be 00; fwd_b follows REQ-021..023 using the registered rt. MEM has priority over WB.
REQ-024 Forwarding shall be combinational from the EX register and the MEM/WB inputs, adding zero latency.
REQ-025 ex_srca shall be the fwd_a-selected value, and ex_wdata the fwd_b-selected value.
REQ-026 ex_srcb shall be the registered immediate when the registered alusrc=1, else ex_wdata.
REQ-027 Register 0 shall never be a forwarding or hazard match.
REQ-028 MDU counter: when an MDU op is captured into EX, the counter shall load MDU_LAT-1 on that edge.
REQ-029 Each cycle the counter is nonzero it shall decrement by 1 and mdu_busy shall be 1.
REQ-030 The counter shall saturate at 0 and never wrap.
REQ-031 Non-MDU instructions shall proceed while mdu_busy=1.

Reset
REQ-032 While rst=1 at a clock edge, the block shall clear ex_valid, ex_regwrite, ex_memtoreg, ex_mdu, ex_wreg, the registered rs/rt/alusrc/operands, and the MDU counter to 0.
REQ-033 After reset, stall_id=0, mdu_busy=0 and fwd_a=fwd_b=00 until new inputs arrive.
REQ-034 Reset asserted mid-stall or mid-MDU-count shall abort that stall or count within one edge.

Configuration
REQ-035 Macro OPFWD_WB_BYPASS_EN, when defined, shall enable the decode-stage bypass.
REQ-036 With the macro defined, at capture, id_rd1 and id_rd2 shall be replaced by wb_result when wb_regwrite=1, wb_wreg!=0 and wb_wreg matches id_rs or id_rt respectively.
REQ-037 With the macro undefined, id_rd1 and id_rd2 shall be captured unmodified, relying on a write-first register file.

Verification
REQ-038 EX rs=3, mem_wreg=3, mem_regwrite=1, mem_aluout=0x11, wb_wreg=3, wb_result=0x22 -> fwd_a=10, ex_srca=0x11.
REQ-039 EX load lw to reg 5 (memtoreg=1), ID add with rs=5 -> stall_id=1 for exactly one cycle; next EX is a bubble (ex_valid=0); the add enters EX the following cycle.
REQ-040 mem_wreg=0, mem_regwrite=1 with EX rs=0 -> fwd_a=00; ex_srca=id_rd1 captured value.
REQ-041 With MDU_LAT=4, mult enters EX, mult in ID one cycle later -> mdu_busy high 3 cycles; stall_id high until mdu_busy falls; an interleaved add is not stalled.
REQ-042 rst pulsed while the MDU counter=2 -> next cycle mdu_busy=0 and ex_valid=0.
REQ-043 With OPFWD_WB_BYPASS_EN, id_rs=7, wb_wreg=7, wb_result=0xAB, id_rd1=0x00 -> next-cycle ex_srca=0xAB with fwd_a=00.

Source files
------------

// File: rtl/operand_forward_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use and multiply/divide stall.
// Optional decode-stage WB bypass is enabled by defining OPFWD_WB_BYPASS_EN.
module operand_forward_stage #(
    parameter int DATA_W  = 32,
    parameter int RA_W    = 5,
    parameter int MDU_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_alusrc,
    input  logic              id_regwrite,
    input  logic              id_memtoreg,
    input  logic              id_mdu,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_wreg,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] mem_aluout,
    input  logic [RA_W-1:0]   mem_wreg,
    input  logic              mem_regwrite,
    input  logic [DATA_W-1:0] wb_result,
    input  logic [RA_W-1:0]   wb_wreg,
    input  logic              wb_regwrite,
    output logic              stall_id,
    output logic [DATA_W-1:0] ex_srca,
    output logic [DATA_W-1:0] ex_srcb,
    output logic [DATA_W-1:0] ex_wdata,
    output logic              ex_valid,
    output logic              ex_regwrite,
    output logic              ex_memtoreg,
    output logic              ex_mdu,
    output logic [RA_W-1:0]   ex_wreg,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mdu_busy
);

    localparam logic [3:0] MDU_LOAD = 4'(MDU_LAT - 1);

    logic [RA_W-1:0]   ex_rs;
    logic [RA_W-1:0]   ex_rt;
    logic              ex_alusrc;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic [DATA_W-1:0] ex_imm;
    logic [3:0]        mdu_cnt;

    logic              load_use;
    logic              mdu_hazard;
    logic              mdu_start;
    logic [DATA_W-1:0] cap_rd1;
    logic [DATA_W-1:0] cap_rd2;

    // Hazards: both terms OR into one stall, so coincident hazards never add cycles.
    assign load_use   = id_valid && ex_valid && ex_regwrite && ex_memtoreg &&
                        (ex_wreg != '0) && ((ex_wreg == id_rs) || (ex_wreg == id_rt));
    assign mdu_busy   = (mdu_cnt != 4'd0);
    assign mdu_hazard = id_valid && id_mdu && mdu_busy;
    assign stall_id   = load_use || mdu_hazard;
    assign mdu_start  = !stall_id && id_valid && id_mdu;

`ifdef OPFWD_WB_BYPASS_EN
    assign cap_rd1 = (wb_regwrite && (wb_wreg != '0) && (wb_wreg == id_rs)) ? wb_result : id_rd1;
    assign cap_rd2 = (wb_regwrite && (wb_wreg != '0) && (wb_wreg == id_rt)) ? wb_result : id_rd2;
`else
    assign cap_rd1 = id_rd1;
    assign cap_rd2 = id_rd2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_mdu      <= 1'b0;
            ex_wreg     <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_alusrc   <= 1'b0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
            mdu_cnt     <= 4'd0;
        end else begin
            if (stall_id) begin
                // Bubble: only control is cleared, datapath fields are left as-is.
                ex_valid    <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memtoreg <= 1'b0;
                ex_mdu      <= 1'b0;
            end else begin
                ex_valid    <= id_valid;
                ex_regwrite <= id_regwrite;
                ex_memtoreg <= id_memtoreg;
                ex_mdu      <= id_mdu;
                ex_wreg     <= id_wreg;
                ex_rs       <= id_rs;
                ex_rt       <= id_rt;
                ex_alusrc   <= id_alusrc;
                ex_rd1      <= cap_rd1;
                ex_rd2      <= cap_rd2;
                ex_imm      <= id_imm;
            end
            if (mdu_start) begin
                mdu_cnt <= MDU_LOAD;
            end else if (mdu_cnt != 4'd0) begin
                mdu_cnt <= mdu_cnt - 4'd1;
            end
        end
    end

    // MEM wins over WB; register 0 never matches.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_regwrite && (mem_wreg != '0) && (mem_wreg == ex_rs)) begin
            fwd_a = 2'b10;
        end else if (wb_regwrite && (wb_wreg != '0) && (wb_wreg == ex_rs)) begin
            fwd_a = 2'b01;
        end
        if (mem_regwrite && (mem_wreg != '0) && (mem_wreg == ex_rt)) begin
            fwd_b = 2'b10;
        end else if (wb_regwrite && (wb_wreg != '0) && (wb_wreg == ex_rt)) begin
            fwd_b = 2'b01;
        end
    end

    always_comb begin
        case (fwd_a)
            2'b10:   ex_srca = mem_aluout;
            2'b01:   ex_srca = wb_result;
            default: ex_srca = ex_rd1;
        endcase
        case (fwd_b)
            2'b10:   ex_wdata = mem_aluout;
            2'b01:   ex_wdata = wb_result;
            default: ex_wdata = ex_rd2;
        endcase
        ex_srcb = ex_alusrc ? ex_imm : ex_wdata;
    end

endmodule

// File: tb/tb_operand_forward_stage.sv
// Bench for operand_forward_stage: reference model, expected-capture queue, directed and random stimulus.
module tb_operand_forward_stage;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int LAT = 4;

    logic          clk;
    logic          rst;
    logic          id_valid, id_alusrc, id_regwrite, id_memtoreg, id_mdu;
    logic [AW-1:0] id_rs, id_rt, id_wreg;
    logic [DW-1:0] id_rd1, id_rd2, id_imm;
    logic [DW-1:0] mem_aluout;
    logic [AW-1:0] mem_wreg;
    logic          mem_regwrite;
    logic [DW-1:0] wb_result;
    logic [AW-1:0] wb_wreg;
    logic          wb_regwrite;
    logic          stall_id;
    logic [DW-1:0] ex_srca, ex_srcb, ex_wdata;
    logic          ex_valid, ex_regwrite, ex_memtoreg, ex_mdu;
    logic [AW-1:0] ex_wreg;
    logic [1:0]    fwd_a, fwd_b;
    logic          mdu_busy;

    operand_forward_stage #(.DATA_W(DW), .RA_W(AW), .MDU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_memtoreg(id_memtoreg), .id_mdu(id_mdu),
        .id_rs(id_rs), .id_rt(id_rt), .id_wreg(id_wreg),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .mem_aluout(mem_aluout), .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite),
        .wb_result(wb_result), .wb_wreg(wb_wreg), .wb_regwrite(wb_regwrite),
        .stall_id(stall_id), .ex_srca(ex_srca), .ex_srcb(ex_srcb), .ex_wdata(ex_wdata),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .ex_mdu(ex_mdu), .ex_wreg(ex_wreg), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mdu_busy(mdu_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    // {datapath known, valid, regwrite, memtoreg, mdu, wreg}
    logic [AW+4:0] exp_q[$];

    // reference model of the EX register and MDU counter
    logic          m_valid, m_regwrite, m_memtoreg, m_mdu, m_alusrc, m_known;
    logic [AW-1:0] m_wreg, m_rs, m_rt;
    logic [DW-1:0] m_rd1, m_rd2, m_imm;
    int            m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] fsel(input logic [AW-1:0] r);
        if (mem_regwrite && mem_wreg != 0 && mem_wreg == r) return 2'b10;
        if (wb_regwrite && wb_wreg != 0 && wb_wreg == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic nop();
        rst = 0; id_valid = 0; id_alusrc = 0; id_regwrite = 0; id_memtoreg = 0; id_mdu = 0;
        id_rs = 0; id_rt = 0; id_wreg = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0;
        mem_aluout = 0; mem_wreg = 0; mem_regwrite = 0;
        wb_result = 0; wb_wreg = 0; wb_regwrite = 0;
    endtask

    task automatic model_clear();
        m_valid = 0; m_regwrite = 0; m_memtoreg = 0; m_mdu = 0; m_alusrc = 0; m_known = 1;
        m_wreg = 0; m_rs = 0; m_rt = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_cnt = 0;
    endtask

    // One cycle: check combinational outputs, push expected capture, clock, pop and compare.
    task automatic step();
        logic          e_stall, e_busy;
        logic [1:0]    e_fa, e_fb;
        logic [DW-1:0] e_a, e_w, c1, c2;
        logic [AW+4:0] e, got;
        #1;
        e_busy  = (m_cnt != 0);
        e_stall = (id_valid && m_valid && m_regwrite && m_memtoreg && m_wreg != 0 &&
                   (m_wreg == id_rs || m_wreg == id_rt)) || (id_valid && id_mdu && e_busy);
        check("stall_id", stall_id, e_stall);
        check("mdu_busy", mdu_busy, e_busy);
        if (m_known) begin
            e_fa = fsel(m_rs);
            e_fb = fsel(m_rt);
            e_a  = (e_fa == 2'b10) ? mem_aluout : (e_fa == 2'b01) ? wb_result : m_rd1;
            e_w  = (e_fb == 2'b10) ? mem_aluout : (e_fb == 2'b01) ? wb_result : m_rd2;
            check("fwd_a", fwd_a, e_fa);
            check("fwd_b", fwd_b, e_fb);
            check("ex_srca", ex_srca, e_a);
            check("ex_wdata", ex_wdata, e_w);
            check("ex_srcb", ex_srcb, m_alusrc ? m_imm : e_w);
        end
        c1 = id_rd1;
        c2 = id_rd2;
`ifdef OPFWD_WB_BYPASS_EN
        if (wb_regwrite && wb_wreg != 0 && wb_wreg == id_rs) c1 = wb_result;
        if (wb_regwrite && wb_wreg != 0 && wb_wreg == id_rt) c2 = wb_result;
`endif
        if (rst)          exp_q.push_back({1'b1, 4'b0000, {AW{1'b0}}});
        else if (e_stall) exp_q.push_back({1'b0, 4'b0000, {AW{1'b0}}});
        else              exp_q.push_back({1'b1, id_valid, id_regwrite, id_memtoreg, id_mdu, id_wreg});
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (!e_stall && id_valid && id_mdu) m_cnt = LAT - 1;
            else if (m_cnt != 0)                m_cnt = m_cnt - 1;
            if (e_stall) begin
                m_valid = 0; m_regwrite = 0; m_memtoreg = 0; m_mdu = 0; m_known = 0;
            end else begin
                m_valid = id_valid; m_regwrite = id_regwrite; m_memtoreg = id_memtoreg;
                m_mdu = id_mdu; m_wreg = id_wreg; m_rs = id_rs; m_rt = id_rt;
                m_alusrc = id_alusrc; m_rd1 = c1; m_rd2 = c2; m_imm = id_imm; m_known = 1;
            end
        end
        #1;
        e   = exp_q.pop_front();
        got = {1'b0, ex_valid, ex_regwrite, ex_memtoreg, ex_mdu, ex_wreg};
        check("ex_ctrl", got[AW+3:AW], e[AW+3:AW]);
        if (e[AW+4]) check("ex_wreg", got[AW-1:0], e[AW-1:0]);
        @(negedge clk);
    endtask

    initial begin
        int st;
        nop();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_clear();
        #1;
        check("rst_stall", stall_id, 1'b0);
        check("rst_busy", mdu_busy, 1'b0);
        check("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
        check("rst_ctrl", {ex_valid, ex_regwrite, ex_memtoreg, ex_mdu, ex_wreg}, '0);
        check("rst_srca", ex_srca, 32'h0);

        // MEM beats WB on the same register
        nop(); id_valid = 1; id_rs = 3; id_rd1 = 32'h55; step();
        nop(); mem_regwrite = 1; mem_wreg = 3; mem_aluout = 32'h11;
        wb_regwrite = 1; wb_wreg = 3; wb_result = 32'h22;
        #1;
        check("mem_prio_fwd", fwd_a, 2'b10);
        check("mem_prio_srca", ex_srca, 32'h11);
        step();

        // WB only, on rt, with immediate select
        nop(); id_valid = 1; id_rt = 4; id_alusrc = 1; id_imm = 32'h7; id_rd2 = 32'h66; step();
        nop(); wb_regwrite = 1; wb_wreg = 4; wb_result = 32'h33;
        #1;
        check("wb_fwd_b", fwd_b, 2'b01);
        check("wb_wdata", ex_wdata, 32'h33);
        check("imm_srcb", ex_srcb, 32'h7);
        step();

        // register 0 never forwards
        nop(); id_valid = 1; id_rs = 0; id_rd1 = 32'h99; step();
        nop(); mem_regwrite = 1; mem_wreg = 0; mem_aluout = 32'hdead;
        #1;
        check("r0_fwd", fwd_a, 2'b00);
        check("r0_srca", ex_srca, 32'h99);
        step();

        // load-use: exactly one bubble
        nop(); id_valid = 1; id_regwrite = 1; id_memtoreg = 1; id_wreg = 5; step();
        nop(); id_valid = 1; id_regwrite = 1; id_wreg = 6; id_rs = 5;
        #1; check("lu_stall", stall_id, 1'b1);
        step();
        #1; check("lu_release", stall_id, 1'b0); check("lu_bubble", ex_valid, 1'b0);
        step();
        #1; check("lu_add_valid", ex_valid, 1'b1); check("lu_add_wreg", ex_wreg, 5'd6);

        // back-to-back multiply: second waits until busy falls
        nop(); id_valid = 1; id_mdu = 1; id_wreg = 8; step();
        st = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!stall_id) break;
            st++;
            step();
        end
        check("mdu_stall_cycles", st, 3);
        step();
        nop(); id_valid = 1; id_regwrite = 1; id_wreg = 9;
        for (int i = 0; i < 3; i++) begin
            #1; check("mdu_add_nostall", stall_id, 1'b0); check("mdu_busy_hi", mdu_busy, 1'b1);
            step();
        end
        #1; check("mdu_busy_lo", mdu_busy, 1'b0);

        // reset in the middle of a count
        nop(); id_valid = 1; id_mdu = 1; step();
        nop(); step();
        #1; check("mid_busy", mdu_busy, 1'b1);
        rst = 1; step(); rst = 0;
        #1; check("rst_abort_busy", mdu_busy, 1'b0); check("rst_abort_valid", ex_valid, 1'b0);

`ifdef OPFWD_WB_BYPASS_EN
        nop(); id_valid = 1; id_rs = 7; id_rd1 = 32'h0;
        wb_regwrite = 1; wb_wreg = 7; wb_result = 32'hAB; step();
        nop();
        #1; check("bypass_srca", ex_srca, 32'hAB); check("bypass_fwd", fwd_a, 2'b00);
        step();
`endif

        // random traffic on a small register set to provoke hazards
        for (int i = 0; i < 300; i++) begin
            rst          = ($urandom_range(0, 39) == 0);
            id_valid     = ($urandom_range(0, 3) != 0);
            id_alusrc    = 1'($urandom_range(0, 1));
            id_regwrite  = 1'($urandom_range(0, 1));
            id_memtoreg  = 1'($urandom_range(0, 1));
            id_mdu       = ($urandom_range(0, 5) == 0);
            id_rs        = AW'($urandom_range(0, 3));
            id_rt        = AW'($urandom_range(0, 3));
            id_wreg      = AW'($urandom_range(0, 3));
            id_rd1       = $urandom;
            id_rd2       = $urandom;
            id_imm       = $urandom;
            mem_aluout   = $urandom;
            mem_wreg     = AW'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom_range(0, 1));
            wb_result    = $urandom;
            wb_wreg      = AW'($urandom_range(0, 3));
            wb_regwrite  = 1'($urandom_range(0, 1));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
